random_priority_arbiter: RTL and testbench
==========================================

RANDOM_PRIORITY_ARBITER -- requirements
Module: random_priority_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters; legal values 2, 4, 8, 16.
REQ-002 SHALL have parameter STARVE_LIMIT, default 15: cycles a requester may wait before it is forced to the front; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port req, input, NUM_REQ: level request per requester.
REQ-006 SHALL have port ack, input, 1: the current grant holder is releasing the resource.
REQ-007 SHALL have port grant, output, NUM_REQ: registered one-hot grant.
REQ-008 SHALL have port grant_valid, output, 1: high when grant is non-zero.
REQ-009 SHALL have port grant_idx, output, log2(NUM_REQ): index of the granted requester; 0 when grant_valid is low.
REQ-010 SHALL have port lfsr_state, output, 11: current LFSR state, for debug.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 SHALL keep an internal 11-bit LFSR; on advance, next = {lfsr[9:0], ~(lfsr[10] ^ lfsr[8])}.
REQ-013 SHALL advance the LFSR only on the edge that makes an arbitration decision (IDLE->GRANT); otherwise it holds its value.
REQ-014 In IDLE with any req bit high, SHALL choose a start index = lfsr[log2(NUM_REQ)-1:0], using the LFSR value before it advances.
REQ-015 SHALL grant the first requester with req high, searching from the start index upward and wrapping modulo NUM_REQ.
REQ-016 SHALL give starvation override precedence over REQ-015: if any wait counter equals STARVE_LIMIT, grant the lowest-index starved requester instead.
REQ-017 Grant latency: req sampled high in IDLE at edge k gives grant, grant_valid and grant_idx visible after edge k, with the FSM in GRANT.
REQ-018 In GRANT, SHALL hold grant constant until ack is sampled high, regardless of req changes, including the holder dropping req.
REQ-019 On ack in GRANT, SHALL clear grant at that edge and move to IDLE; no new grant in the same cycle (one dead cycle minimum between grants).
REQ-020 SHALL ignore ack while in IDLE.
REQ-021 SHALL keep one wait counter per requester, saturating at STARVE_LIMIT.
REQ-022 Each wait counter SHALL increment every cycle its req is high and it is not the granted requester.
REQ-023 Each wait counter SHALL clear on the edge its requester is granted, or on any cycle its req is low.
REQ-024 When req is all zero in IDLE, SHALL keep grant at 0, keep the FSM in IDLE, and leave the LFSR unchanged.
REQ-025 grant SHALL always be one-hot or zero; grant_valid SHALL equal (grant != 0).

Reset
REQ-026 With rst low at an edge, SHALL set: FSM to IDLE, grant = 0, grant_valid = 0, grant_idx = 0, lfsr = 11'h001, all wait counters = 0.
REQ-027 Reset asserted during GRANT SHALL drop grant at that same edge; no ack is required.
REQ-028 Until the first edge with rst high, outputs SHALL remain at their reset values.

Verification
REQ-029 Scenario, single requester: NUM_REQ=4; reset, then req=4'b0100 -> grant=4'b0100 and grant_idx=2 one edge later; lfsr_state=11'h003.
REQ-030 Scenario, LFSR-driven start: req=4'b1111 held, ack pulsed each time grant appears.
  -> First grant idx 1 (lfsr 0x001).
  -> Dead cycle, then idx 3 (lfsr 0x003).
  -> lfsr_state then reads 0x007.
REQ-031 Scenario, grant hold: holder drops req and ack stays low for 10 cycles -> grant unchanged throughout; ack -> grant=0 next edge, FSM in IDLE.
REQ-032 Scenario, starvation: STARVE_LIMIT=3, req[0] held while others keep winning -> req[0] granted on the first decision after its counter reaches 3.
REQ-033 Scenario, reset mid-grant: rst low while grant=4'b1000 -> grant=0 and lfsr_state=0x001 after that edge; ack during reset has no effect.
REQ-034 Scenario, continuous checks: assertions that grant is one-hot-or-zero, that grant_valid equals (grant != 0), and that no requester waits more than STARVE_LIMIT + NUM_REQ decisions.

Source files
------------

// File: rtl/random_priority_arbiter.sv
// Random-start priority arbiter.
// An 11-bit LFSR picks the index where the search for a requester starts.
// Per-requester wait counters force a long-waiting requester to the front.
// A grant is held until the holder acknowledges it.
module random_priority_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       ack,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic [10:0]                lfsr_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [10:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    wait_q [NUM_REQ];
  logic [CNT_W-1:0]    wait_d [NUM_REQ];

  logic                starve_hit;
  logic [IDX_W-1:0]    starve_idx;
  logic                rr_hit;
  logic [IDX_W-1:0]    rr_idx;
  logic [IDX_W-1:0]    start_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic [IDX_W-1:0]    win_idx;
  logic                decide;

  // Pick the winner: lowest-index starved requester first, otherwise the
  // first requester found searching upward (with wrap) from the LFSR start.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    rr_hit     = 1'b0;
    rr_idx     = '0;
    cand_idx   = '0;
    start_idx  = lfsr_q[IDX_W-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!starve_hit && req[i] && (wait_q[i] == LIMIT_C)) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = start_idx + IDX_W'(k);
      if (!rr_hit && req[cand_idx]) begin
        rr_hit = 1'b1;
        rr_idx = cand_idx;
      end
    end
    win_idx = starve_hit ? starve_idx : rr_idx;
  end

  // Next-state logic: decide in IDLE (advancing the LFSR), hold in GRANT until ack.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    lfsr_d      = lfsr_q;
    decide      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          decide      = 1'b1;
          state_d     = GRANT;
          grant_d     = NUM_REQ'(1) << win_idx;
          grant_idx_d = win_idx;
          lfsr_d      = {lfsr_q[9:0], ~(lfsr_q[10] ^ lfsr_q[8])};
        end
      end
      GRANT: begin
        if (ack) begin
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        grant_idx_d = '0;
      end
    endcase
  end

  // Wait counters: clear when idle-requesting stops or when granted, else saturate upward.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (!req[i] || grant_q[i] || (decide && (win_idx == IDX_W'(i)))) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != LIMIT_C) begin
        wait_d[i] = wait_q[i] + CNT_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      lfsr_q      <= 11'h001;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      lfsr_q      <= lfsr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = grant_idx_q;
  assign lfsr_state  = lfsr_q;

endmodule

// File: tb/tb_random_priority_arbiter.sv
// Testbench for random_priority_arbiter.
// Two instances share the stimulus: one with a short starvation limit,
// one with the default limit; each is tracked by its own reference model.
module tb_random_priority_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;

  logic [3:0]  grant_a, grant_b;
  logic        valid_a, valid_b;
  logic [1:0]  idx_a, idx_b;
  logic [10:0] lfsr_a, lfsr_b;

  int vectors;
  int miscompares;

  int m_holder [2];
  int m_lfsr   [2];
  int m_wait   [2][4];
  int lim      [2];

  logic [3:0] prev_grant_b;
  int         wait_dec [4];

  random_priority_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(3)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .grant       (grant_a),
    .grant_valid (valid_a),
    .grant_idx   (idx_a),
    .lfsr_state  (lfsr_a)
  );

  random_priority_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(15)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .grant       (grant_b),
    .grant_valid (valid_b),
    .grant_idx   (idx_b),
    .lfsr_state  (lfsr_b)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: who holds the resource, the LFSR as an integer, and
  // how many cycles each requester has waited.
  function automatic void modelStep(input int u, input logic r, input logic [3:0] rq, input logic a);
    int decided;
    int start;
    decided = -1;
    if (!r) begin
      m_holder[u] = -1;
      m_lfsr[u]   = 1;
      for (int i = 0; i < 4; i++) m_wait[u][i] = 0;
      return;
    end
    if (m_holder[u] < 0 && rq != 4'b0000) begin
      for (int i = 0; i < 4; i++)
        if (decided < 0 && rq[i] && m_wait[u][i] == lim[u]) decided = i;
      if (decided < 0) begin
        start = m_lfsr[u] % 4;
        for (int k = 0; k < 4; k++)
          if (decided < 0 && rq[(start + k) % 4]) decided = (start + k) % 4;
      end
      m_lfsr[u] = ((m_lfsr[u] << 1) & 'h7FF) | ((((m_lfsr[u] >> 10) ^ (m_lfsr[u] >> 8)) & 1) ^ 1);
    end
    for (int i = 0; i < 4; i++) begin
      if (!rq[i] || i == m_holder[u] || i == decided) m_wait[u][i] = 0;
      else if (m_wait[u][i] < lim[u]) m_wait[u][i] = m_wait[u][i] + 1;
    end
    if (decided >= 0) m_holder[u] = decided;
    else if (m_holder[u] >= 0 && a) m_holder[u] = -1;
  endfunction

  function automatic logic [31:0] expGrant(input int u);
    return (m_holder[u] >= 0) ? (32'd1 << m_holder[u]) : 32'd0;
  endfunction

  function automatic logic [31:0] expIdx(input int u);
    return (m_holder[u] >= 0) ? 32'(m_holder[u]) : 32'd0;
  endfunction

  // Drive one cycle of inputs, advance the models, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic a);
    int max_wait;
    @(negedge clk);
    rst = r;
    req = rq;
    ack = a;
    @(posedge clk);
    modelStep(0, r, rq, a);
    modelStep(1, r, rq, a);
    #1;
    checkOutput("a.grant", 32'(grant_a), expGrant(0));
    checkOutput("a.valid", 32'(valid_a), 32'(m_holder[0] >= 0));
    checkOutput("a.idx",   32'(idx_a),   expIdx(0));
    checkOutput("a.lfsr",  32'(lfsr_a),  32'(m_lfsr[0]));
    checkOutput("b.grant", 32'(grant_b), expGrant(1));
    checkOutput("b.valid", 32'(valid_b), 32'(m_holder[1] >= 0));
    checkOutput("b.idx",   32'(idx_b),   expIdx(1));
    checkOutput("b.lfsr",  32'(lfsr_b),  32'(m_lfsr[1]));
    checkOutput("a.onehot0", 32'($onehot0(grant_a)), 32'd1);
    checkOutput("b.onehot0", 32'($onehot0(grant_b)), 32'd1);
    checkOutput("a.valid_vs_grant", 32'(valid_a), 32'(grant_a != 4'b0000));
    checkOutput("b.valid_vs_grant", 32'(valid_b), 32'(grant_b != 4'b0000));
    max_wait = 0;
    for (int i = 0; i < 4; i++) begin
      if (!r || !rq[i]) wait_dec[i] = 0;
      else if (prev_grant_b == 4'b0000 && grant_b != 4'b0000) begin
        if (grant_b[i]) wait_dec[i] = 0;
        else wait_dec[i] = wait_dec[i] + 1;
      end
      if (wait_dec[i] > max_wait) max_wait = wait_dec[i];
    end
    checkOutput("b.wait_bound", 32'(max_wait <= 15 + 4), 32'd1);
    prev_grant_b = grant_b;
  endtask

  // Directed scenarios followed by a randomized run, all checked against the models.
  initial begin
    logic [3:0] rnd_req;
    vectors      = 0;
    miscompares  = 0;
    lim[0]       = 3;
    lim[1]       = 15;
    prev_grant_b = 4'b0000;
    for (int i = 0; i < 4; i++) wait_dec[i] = 0;
    rst = 1'b0;
    req = 4'b0000;
    ack = 1'b0;

    // Reset values
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("rst.grant", 32'(grant_a), 32'd0);
    checkOutput("rst.valid", 32'(valid_a), 32'd0);
    checkOutput("rst.idx",   32'(idx_a),   32'd0);
    checkOutput("rst.lfsr",  32'(lfsr_a),  32'h001);

    // Single requester
    applyStimulus(1'b1, 4'b0100, 1'b0);
    checkOutput("single.grant", 32'(grant_a), 32'h4);
    checkOutput("single.idx",   32'(idx_a),   32'd2);
    checkOutput("single.lfsr",  32'(lfsr_a),  32'h003);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("single.release", 32'(grant_a), 32'd0);

    // LFSR-driven start with all requesting
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("lfsr.first_idx",  32'(idx_a),  32'd1);
    checkOutput("lfsr.first_lfsr", 32'(lfsr_a), 32'h003);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("lfsr.dead_cycle", 32'(grant_a), 32'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("lfsr.second_idx",  32'(idx_a),  32'd3);
    checkOutput("lfsr.second_lfsr", 32'(lfsr_a), 32'h007);

    // Grant hold while the holder drops req
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 4'b0111, 1'b0);
      checkOutput("hold.grant", 32'(grant_a), 32'h8);
    end
    applyStimulus(1'b1, 4'b0111, 1'b1);
    checkOutput("hold.release", 32'(grant_a), 32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("idle.no_req_grant", 32'(grant_a), 32'd0);
    checkOutput("idle.no_req_lfsr",  32'(lfsr_a),  32'h007);

    // Starvation override: limit 3 forces requester 0, limit 15 follows the LFSR
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("starve.a_grant", 32'(grant_a), 32'h1);
    checkOutput("starve.b_grant", 32'(grant_b), 32'h8);
    applyStimulus(1'b1, 4'b1111, 1'b1);

    // Reset in the middle of a grant, with ack asserted
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0);
    checkOutput("midrst.before", 32'(grant_a), 32'h8);
    applyStimulus(1'b0, 4'b1000, 1'b1);
    checkOutput("midrst.grant", 32'(grant_a), 32'd0);
    checkOutput("midrst.lfsr",  32'(lfsr_a),  32'h001);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("midrst.after_grant", 32'(grant_a), 32'd0);
    checkOutput("midrst.after_lfsr",  32'(lfsr_a),  32'h001);

    // Randomized traffic with occasional resets
    rnd_req = 4'b1111;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 79) != 0), rnd_req, ($urandom_range(0, 2) == 0));
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
